// File: rtl/group_enable_scheduler.sv
// Round-robin scheduler that hands the shared pixel readout path to one
// pixel group at a time. It drives a one-hot enable matrix and holds each grant
// until the group releases, drops its request while idle, or hits the watchdog.
module group_enable_scheduler #(
   parameter int GRP_ROWS = 8,
   parameter int GRP_COLS = 8,
   parameter int GRP_ADD  = 3,
   parameter int TIMEOUT  = 64,
   parameter int TMR_W    = 8
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [GRP_ROWS-1:0][GRP_COLS-1:0]  req_i,
   input  logic                               active_i,
   input  logic                               grp_release_i,
   output logic [GRP_ROWS-1:0][GRP_COLS-1:0]  enable_o,
   output logic [GRP_ADD-1:0]                 grp_x_o,
   output logic [GRP_ADD-1:0]                 grp_y_o,
   output logic                               valid_o,
   output logic                               timeout_o,
   output logic [15:0]                        grant_cnt_o
);

   localparam int N     = GRP_ROWS * GRP_COLS;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
   localparam logic             WDOG_ON  = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] sel;
   logic [IDX_W-1:0] sel_nxt;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_nxt;
   logic [TMR_W-1:0] timer;
   logic [TMR_W-1:0] timer_nxt;
   logic             timeout_nxt;
   logic [15:0]      cnt_nxt;

   logic [N-1:0]     req_flat;
   logic             any_req;
   logic [IDX_W-1:0] winner;
   logic             exit_rel;
   logic             exit_drop;
   logic             exit_tmo;
   logic [N-1:0]     en_flat;

   // Packed row/column matrix flattens to bit row*GRP_COLS+col.
   assign req_flat = req_i;
   assign any_req  = |req_flat;

   // Exit reasons for the current grant; release outranks a drop, which outranks the watchdog.
   assign exit_rel  = grp_release_i;
   assign exit_drop = ~req_flat[sel] & ~active_i;
   assign exit_tmo  = WDOG_ON & (timer == TMR_LAST);

   // Rotating-priority search: ptr+1 first, ptr itself last, so nobody starves.
   always_comb begin
      int               pos;
      logic [IDX_W-1:0] pos_idx;
      pos     = 0;
      pos_idx = '0;
      winner  = ptr;
      // Walk from the farthest offset down so the nearest requester wins.
      for (int k = N; k >= 1; k--) begin
         pos = int'(ptr) + k;
         if (pos >= N) begin
            pos = pos - N;
         end
         pos_idx = IDX_W'(pos);
         if (req_flat[pos_idx]) begin
            winner = pos_idx;
         end
      end
   end

   // Next-state logic: arbitrate from IDLE/GAP, watch exit conditions in GRANT.
   always_comb begin
      state_nxt   = state;
      sel_nxt     = sel;
      ptr_nxt     = ptr;
      timer_nxt   = timer;
      timeout_nxt = 1'b0;
      cnt_nxt     = grant_cnt_o;
      case (state)
         S_IDLE, S_GAP: begin
            if (any_req) begin
               state_nxt = S_GRANT;
               sel_nxt   = winner;
               timer_nxt = '0;
               if (grant_cnt_o != 16'hFFFF) begin
                  cnt_nxt = grant_cnt_o + 16'd1;
               end
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_GRANT: begin
            timer_nxt = timer + TMR_W'(1);
            if (exit_rel | exit_drop | exit_tmo) begin
               state_nxt   = S_GAP;
               ptr_nxt     = sel;
               // Watchdog only reports when it is the sole reason for leaving.
               timeout_nxt = ~exit_rel & ~exit_drop & exit_tmo;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // State, selection, pointer, watchdog and grant counter registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state       <= S_IDLE;
         sel         <= '0;
         ptr         <= LAST_IDX;
         timer       <= '0;
         timeout_o   <= 1'b0;
         grant_cnt_o <= '0;
      end else begin
         state       <= state_nxt;
         sel         <= sel_nxt;
         ptr         <= ptr_nxt;
         timer       <= timer_nxt;
         timeout_o   <= timeout_nxt;
         grant_cnt_o <= cnt_nxt;
      end
   end

   // Decode the enable matrix and coordinates from state; all zero outside GRANT.
   always_comb begin
      en_flat = '0;
      valid_o = 1'b0;
      grp_x_o = '0;
      grp_y_o = '0;
      if (state == S_GRANT) begin
         en_flat[sel] = 1'b1;
         valid_o      = 1'b1;
         grp_x_o      = GRP_ADD'(int'(sel) % GRP_COLS);
         grp_y_o      = GRP_ADD'(int'(sel) / GRP_COLS);
      end
      enable_o = en_flat;
   end

endmodule

// File: doc/group_enable_scheduler.md
# group_enable_scheduler

Round-robin scheduler that shares the pixel-level readout path among the pixel groups of one hierarchy level. It sits above the group array. It watches the per-group request summaries and drives the one-hot group `enable` matrix, so exactly one group is enabled at a time. It holds that enable until the group signals release, drops its request, or times out, then advances fairly to the next requesting group.

## Interface
- `GRP_ROWS`, 8, rows of groups in the level
- `GRP_COLS`, 8, columns of groups in the level
- `GRP_ADD`, 3, width of group row/column index; must satisfy 2^GRP_ADD ≥ max(GRP_ROWS, GRP_COLS)
- `TIMEOUT`, 64, maximum GRANT cycles per group; 0 disables the watchdog
- `TMR_W`, 8, watchdog counter width; must satisfy 2^TMR_W > TIMEOUT
- `clk_i`  in  1  clock, rising edge
- `reset_i`  in  1  reset, asynchronous, active-high
- `req_i`  in  [GRP_ROWS-1:0][GRP_COLS-1:0]  per-group request summary (OR of pixel requests)
- `active_i`  in  1  enabled group still has a transfer in progress
- `grp_release_i`  in  1  enabled group has finished and yields the path
- `enable_o`  out  [GRP_ROWS-1:0][GRP_COLS-1:0]  one-hot group enable, all-zero when none selected
- `grp_x_o`  out  GRP_ADD  column index of enabled group
- `grp_y_o`  out  GRP_ADD  row index of enabled group
- `valid_o`  out  1  high while in GRANT; qualifies `grp_x_o`/`grp_y_o`
- `timeout_o`  out  1  one-cycle pulse when the watchdog forces a release
- `grant_cnt_o`  out  16  saturating count of grants issued since reset

## Operation
- Flat index: i = row*GRP_COLS + col, N = GRP_ROWS*GRP_COLS.
- `ptr` holds the last served index. Its reset value is N-1, so the first search starts at index 0.
- Search order is ptr+1, ptr+2, …, wrapping mod N, ending with ptr itself. The first set `req_i` bit in that order wins.
- State IDLE:
  - `enable_o`=0, `valid_o`=0.
  - If any `req_i` is set: latch `sel` = winner, clear the timer, go to GRANT.
- State GRANT:
  - `enable_o` bit `sel` = 1, all others 0.
  - `valid_o`=1; `grp_x_o`=sel%GRP_COLS, `grp_y_o`=sel/GRP_COLS.
  - The timer increments each cycle.
- Exit from GRANT to GAP, checked in priority order:
  - (a) `grp_release_i`=1;
  - (b) `req_i[sel]`=0 and `active_i`=0;
  - (c) TIMEOUT≠0 and timer = TIMEOUT-1, which also pulses `timeout_o` on the transition edge.
- On any exit: `ptr` ← `sel`; `grant_cnt_o` increments (saturating at 0xFFFF) on entry to GRANT, not on exit.
- A dropped `req_i[sel]` while `active_i`=1 does not end the grant.
- State GAP:
  - Exactly one cycle with `enable_o`=0, `valid_o`=0, so the released group can settle.
  - Arbitrates like IDLE: if any request, go to GRANT with the new winner; otherwise go to IDLE.
- Invariant: `enable_o` is never multi-hot in any cycle.
- While `valid_o`=0, `grp_x_o`/`grp_y_o` hold 0.

## Timing
- Reset (asynchronous assertion) drives immediately:
  - outputs: `enable_o`=0, `grp_x_o`=0, `grp_y_o`=0, `valid_o`=0, `timeout_o`=0, `grant_cnt_o`=0;
  - internal: state=IDLE, ptr=N-1, timer=0.
- Reset mid-GRANT drops the enable in the same cycle. The first post-reset grant restarts search from index 0.
- Request latency: `req_i` sampled high on edge t gives `enable_o` high from edge t+1.
- Release-to-next: exit condition sampled on edge t gives GAP (enable 0) for cycle t+1, and the next group is enabled from edge t+2.
- A sole requester re-requesting is re-granted after the single GAP cycle.
- Timeout: without release, GRANT lasts exactly TIMEOUT cycles. `timeout_o` is high in the first GAP cycle only.
- Release and timeout in the same cycle: treated as a release, `timeout_o` stays 0.
- Wrap-around: with ptr=N-1, index 0 is checked first; with ptr=k, index k is checked last (no starvation).
- `req_i` changes during GRANT affect only the next arbitration.

## Test plan
- Reset, then `req_i` bits (0,0) and (3,5) set -> edge after request: `enable_o`[0][0]=1, grp_x=0, grp_y=0, `grant_cnt_o`=1. Release pulse -> one zero cycle, then `enable_o`[3][5]=1, grp_x=5, grp_y=3, count=2.
- All 64 requests held high, release one cycle after each grant -> grants visit indices 0..63 in order, then wrap to 0; `enable_o` is always ≤1-hot.
- Single request at (7,7), no release, `active_i`=1, TIMEOUT=64 -> `valid_o` high exactly 64 cycles, `timeout_o` pulses once, re-grant of (7,7) two edges after the timeout edge.
- `grp_release_i` asserted on cycle 63 of GRANT (coincident with timeout) -> `timeout_o` stays 0, normal release.
- During GRANT of (2,2), drop `req_i`[2][2] with `active_i`=1 -> grant held; then drop `active_i` -> exit to GAP next edge.
- Assert `reset_i` mid-GRANT of (4,1) -> `enable_o`/`valid_o`/`grant_cnt_o` zero asynchronously; after release with (4,1) and (0,3) requesting -> (0,3) granted first.
